// File: rtl/sim_trace_ctrl_if.sv
// Trace FIFO drain channel: head entry plus valid/ready handshake.
interface sim_trace_ctrl_if #(parameter int DATA_W = 32);
  logic              trace_valid;
  logic              trace_ready;
  logic [DATA_W-1:0] trace_pc;
  logic [DATA_W-1:0] trace_inst;
  logic              trace_dmw;

  modport master (output trace_valid, trace_pc, trace_inst, trace_dmw, input trace_ready);
  modport slave  (input trace_valid, trace_pc, trace_inst, trace_dmw, output trace_ready);
endinterface

// File: rtl/sim_trace_ctrl.sv
// CPU run control (halt/run/step/breakpoints) with a clock-enable divider
// and a trace FIFO recording every committed CPU cycle.
module sim_trace_ctrl #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 2,
  parameter int NUM_BP  = 2
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic [1:0]               mode,
  input  logic                     step_req,
  input  logic [NUM_BP*DATA_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic [DATA_W-1:0]        pc,
  input  logic [DATA_W-1:0]        inst,
  input  logic                     dm_w,
  output logic                     cpu_ce,
  output logic                     halted,
  output logic [NUM_BP-1:0]        bp_hit,
  sim_trace_ctrl_if.master         trace,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     overflow,
  output logic [31:0]              cycle_cnt
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP, S_BREAK} state_t;
  state_t state, state_nx;

  logic [DIV_W-1:0]  div_cnt;
  logic              tick, skip_bp, skip_set, skip_clr, hit_ld, hit_clr;
  logic [NUM_BP-1:0] bp_match;
  logic              run_mode;

  assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign run_mode = (mode == 2'b01);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    assign bp_match[i] = bp_en[i] && (pc == bp_addr[i*DATA_W +: DATA_W]);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state   <= S_HALT;
      skip_bp <= 1'b0;
      bp_hit  <= '0;
    end else begin
      state <= state_nx;
      if (skip_set)      skip_bp <= 1'b1;
      else if (skip_clr) skip_bp <= 1'b0;
      if (hit_ld)        bp_hit <= bp_match;
      else if (hit_clr)  bp_hit <= '0;
    end
  end

  // skip_bp lets a resume from HALT step over a breakpoint sitting on the current PC.
  always_comb begin
    state_nx = state;
    cpu_ce   = 1'b0;
    skip_set = 1'b0;
    skip_clr = 1'b0;
    hit_ld   = 1'b0;
    hit_clr  = 1'b0;
    case (state)
      S_HALT:
        if (run_mode) begin
          state_nx = S_RUN;
          skip_set = 1'b1;
        end else if (step_req) state_nx = S_STEP;
      S_RUN:
        if (!run_mode) state_nx = S_HALT;
        else if (tick) begin
          if ((|bp_match) && !skip_bp) begin
            state_nx = S_BREAK;
            hit_ld   = 1'b1;
          end else begin
            cpu_ce   = 1'b1;
            skip_clr = 1'b1;
          end
        end
      S_STEP:
        if (tick) begin
          cpu_ce   = 1'b1;
          state_nx = S_HALT;
        end
      S_BREAK:
        if (step_req) begin
          state_nx = S_STEP;
          hit_clr  = 1'b1;
        end else if (!run_mode) begin
          state_nx = S_HALT;
          hit_clr  = 1'b1;
        end
      default: state_nx = S_HALT;
    endcase
  end

  assign halted = (state == S_HALT) || (state == S_BREAK);

  // Trace FIFO
  logic [DATA_W-1:0] mem_pc   [DEPTH];
  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic              mem_dmw  [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = trace.trace_valid && trace.trace_ready;
  // When full, a push only fits if the head leaves on the same edge.
  assign do_push = cpu_ce && (!full || do_pop);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
        mem_dmw[i]  <= 1'b0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if (do_push) begin
        mem_pc[wr_ptr]   <= pc;
        mem_inst[wr_ptr] <= inst;
        mem_dmw[wr_ptr]  <= dm_w;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (cpu_ce && full && !do_pop) overflow <= 1'b1;
      if (cpu_ce) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  assign trace.trace_valid = (count != '0);
  assign trace.trace_pc    = mem_pc[rd_ptr];
  assign trace.trace_inst  = mem_inst[rd_ptr];
  assign trace.trace_dmw   = mem_dmw[rd_ptr];
  assign trace_count       = count;
endmodule
